// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the ALU operand stage: operand widths, ALU op
// codes, the stage-state encoding and the held-instruction record.
package pipeline_pkg;

    localparam int DATA_W  = 16;
    localparam int REG_W   = 3;
    localparam int STALL_W = 8;

    localparam logic [REG_W-1:0] REG_ZERO = 3'd0;

    typedef enum logic [1:0] {
        ALU_OP_AND  = 2'b00,
        ALU_OP_ADD  = 2'b01,
        ALU_OP_SUB  = 2'b10,
        ALU_OP_RSVD = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_HAZARD = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        alu_op_e           alu_op;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic              mem_read;
    } entry_t;

    // r0 is hard-wired zero, so a write to it never produces a value worth matching.
    function automatic logic reg_hit(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rd,
        input logic             rd_write
    );
        return rd_write && (rd != REG_ZERO) && (rd == rs);
    endfunction

endpackage

// File: rtl/forward_mux.sv
// Selects the newest value of one source register: EX/MEM ALU result first,
// then MEM/WB result, else the value read from the register file.
module forward_mux
    import pipeline_pkg::*;
(
    input  logic [REG_W-1:0]  rs,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic              exmem_reg_write,
    input  logic              exmem_mem_read,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] fwd_data
);

    // NOTE: assign a default before any branch so every path drives fwd_data and no latch is inferred.
    always_comb begin
        fwd_data = rf_data;
        if (rs != REG_ZERO) begin
            // A load in EX/MEM has no data yet; the hazard logic stalls for it instead.
            if (reg_hit(rs, exmem_rd, exmem_reg_write) && !exmem_mem_read) begin
                fwd_data = exmem_result;
            end else if (reg_hit(rs, memwb_rd, memwb_reg_write)) begin
                fwd_data = memwb_result;
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage: holds one decoded instruction, resolves forwarding and load-use
// hazards, and hands signed ALU operands to EX under a valid/ready handshake.
module alu_operand_stage
    import pipeline_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [REG_W-1:0]         in_rs1,
    input  logic [REG_W-1:0]         in_rs2,
    input  logic [DATA_W-1:0]        in_rs1_data,
    input  logic [DATA_W-1:0]        in_rs2_data,
    input  logic [DATA_W-1:0]        in_imm,
    input  logic                     in_use_imm,
    input  logic [1:0]               in_alu_op,
    input  logic [REG_W-1:0]         in_rd,
    input  logic                     in_reg_write,
    input  logic                     in_mem_read,

    input  logic [REG_W-1:0]         exmem_rd,
    input  logic                     exmem_reg_write,
    input  logic                     exmem_mem_read,
    input  logic [DATA_W-1:0]        exmem_result,
    input  logic [REG_W-1:0]         memwb_rd,
    input  logic                     memwb_reg_write,
    input  logic [DATA_W-1:0]        memwb_result,

    input  logic                     flush,
    input  logic                     out_ready,

    output logic signed [DATA_W-1:0] A,
    output logic signed [DATA_W-1:0] B,
    output logic [1:0]               ALUop,
    output logic                     out_valid,
    output logic [REG_W-1:0]         out_rd,
    output logic                     out_reg_write,
    output logic                     out_mem_read,
    output logic [STALL_W-1:0]       stall_count
);

    stage_state_e       state_q, state_d;
    entry_t             entry_q, entry_d;
    entry_t             entry_in;
    logic [STALL_W-1:0] stall_count_q, stall_count_d;
    logic               alive_q, alive_d;
    logic               hazard;
    logic               accept;
    logic [DATA_W-1:0]  rs1_fwd;
    logic [DATA_W-1:0]  rs2_fwd;

    // A load still in EX/MEM cannot be forwarded; any held source waiting on it must stall.
    assign hazard = (state_q != ST_EMPTY) && exmem_mem_read &&
                    (reg_hit(entry_q.rs1, exmem_rd, exmem_reg_write) ||
                     (!entry_q.use_imm && reg_hit(entry_q.rs2, exmem_rd, exmem_reg_write)));

    // alive_q holds in_ready low while reset is asserted and releases it one edge later.
    assign alive_d = 1'b1;

    always_comb begin
        in_ready = 1'b0;
        if (alive_q) begin
            unique case (state_q)
                ST_EMPTY: in_ready = 1'b1;
                ST_FULL:  in_ready = out_ready && !hazard;
                default:  in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready && !flush;

    always_comb begin
        entry_in.rs1       = in_rs1;
        entry_in.rs2       = in_rs2;
        entry_in.rs1_data  = in_rs1_data;
        entry_in.rs2_data  = in_rs2_data;
        entry_in.imm       = in_imm;
        entry_in.use_imm   = in_use_imm;
        entry_in.alu_op    = alu_op_e'(in_alu_op);
        entry_in.rd        = in_rd;
        entry_in.reg_write = in_reg_write;
        entry_in.mem_read  = in_mem_read;
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        if (accept) begin
            entry_d = entry_in;
        end
        // Flush outranks both accept and hazard: whatever is held or offered is dropped.
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) state_d = ST_FULL;
                end
                ST_FULL: begin
                    if (hazard) begin
                        state_d = ST_HAZARD;
                    end else if (out_ready) begin
                        state_d = accept ? ST_FULL : ST_EMPTY;
                    end
                end
                ST_HAZARD: begin
                    if (!hazard) state_d = ST_FULL;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if ((state_q == ST_HAZARD) && (stall_count_q != {STALL_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // NOTE: the held entry is only a few dozen flops, so it is reset outright; a RAM-style store would not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            entry_q       <= '0;
            stall_count_q <= '0;
            alive_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q       <= state_d;
            entry_q       <= entry_d;
            stall_count_q <= stall_count_d;
            alive_q       <= alive_d;
        end
    end

    forward_mux u_fwd_rs1 (
        .rs              (entry_q.rs1),
        .rf_data         (entry_q.rs1_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_mem_read  (exmem_mem_read),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd_data        (rs1_fwd)
    );

    forward_mux u_fwd_rs2 (
        .rs              (entry_q.rs2),
        .rf_data         (entry_q.rs2_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_mem_read  (exmem_mem_read),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd_data        (rs2_fwd)
    );

    assign A             = rs1_fwd;
    assign B             = entry_q.use_imm ? entry_q.imm : rs2_fwd;
    assign ALUop         = entry_q.alu_op;
    assign out_valid     = (state_q == ST_FULL) && !hazard;
    assign out_rd        = entry_q.rd;
    assign out_reg_write = entry_q.reg_write;
    assign out_mem_read  = entry_q.mem_read;
    assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: a table of single-instruction vectors plus hand-written
// hazard, back-pressure, flush and reset sequences, with an issue scoreboard.
module tb_alu_operand_stage;
    import pipeline_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_rs1, in_rs2;
    logic [15:0]        in_rs1_data, in_rs2_data, in_imm;
    logic               in_use_imm;
    logic [1:0]         in_alu_op;
    logic [2:0]         in_rd;
    logic               in_reg_write, in_mem_read;
    logic [2:0]         exmem_rd;
    logic               exmem_reg_write, exmem_mem_read;
    logic [15:0]        exmem_result;
    logic [2:0]         memwb_rd;
    logic               memwb_reg_write;
    logic [15:0]        memwb_result;
    logic               flush, out_ready;
    logic signed [15:0] A, B;
    logic [1:0]         ALUop;
    logic               out_valid;
    logic [2:0]         out_rd;
    logic               out_reg_write, out_mem_read;
    logic [7:0]         stall_count;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_rs1_data     (in_rs1_data),
        .in_rs2_data     (in_rs2_data),
        .in_imm          (in_imm),
        .in_use_imm      (in_use_imm),
        .in_alu_op       (in_alu_op),
        .in_rd           (in_rd),
        .in_reg_write    (in_reg_write),
        .in_mem_read     (in_mem_read),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_mem_read  (exmem_mem_read),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .flush           (flush),
        .out_ready       (out_ready),
        .A               (A),
        .B               (B),
        .ALUop           (ALUop),
        .out_valid       (out_valid),
        .out_rd          (out_rd),
        .out_reg_write   (out_reg_write),
        .out_mem_read    (out_mem_read),
        .stall_count     (stall_count)
    );

    typedef struct {
        logic [2:0]  rs1, rs2;
        logic [15:0] rs1_data, rs2_data;
        logic        use_imm;
        logic [15:0] imm;
        logic [1:0]  alu_op;
        logic [2:0]  rd;
        logic        reg_write, mem_read;
        logic [2:0]  ex_rd;
        logic        ex_rw, ex_mr;
        logic [15:0] ex_res;
        logic [2:0]  wb_rd;
        logic        wb_rw;
        logic [15:0] wb_res;
        logic [15:0] exp_a, exp_b;
    } vec_t;

    typedef struct {
        logic [15:0] a, b;
        logic [1:0]  op;
        logic [2:0]  rd;
        logic        rw, mr;
    } exp_t;

    exp_t sb_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   exp_stall = 0;

    function automatic vec_t mk(
        input logic [2:0] rs1, input logic [2:0] rs2,
        input logic [15:0] rs1_data, input logic [15:0] rs2_data,
        input logic use_imm, input logic [15:0] imm, input logic [1:0] alu_op,
        input logic [2:0] rd, input logic reg_write, input logic mem_read,
        input logic [2:0] ex_rd, input logic ex_rw, input logic ex_mr, input logic [15:0] ex_res,
        input logic [2:0] wb_rd, input logic wb_rw, input logic [15:0] wb_res,
        input logic [15:0] exp_a, input logic [15:0] exp_b
    );
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rs1_data = rs1_data; v.rs2_data = rs2_data;
        v.use_imm = use_imm; v.imm = imm; v.alu_op = alu_op;
        v.rd = rd; v.reg_write = reg_write; v.mem_read = mem_read;
        v.ex_rd = ex_rd; v.ex_rw = ex_rw; v.ex_mr = ex_mr; v.ex_res = ex_res;
        v.wb_rd = wb_rd; v.wb_rw = wb_rw; v.wb_res = wb_res;
        v.exp_a = exp_a; v.exp_b = exp_b;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_rs1_data = v.rs1_data; in_rs2_data = v.rs2_data;
        in_use_imm = v.use_imm; in_imm = v.imm; in_alu_op = v.alu_op;
        in_rd = v.rd; in_reg_write = v.reg_write; in_mem_read = v.mem_read;
        exmem_rd = v.ex_rd; exmem_reg_write = v.ex_rw; exmem_mem_read = v.ex_mr; exmem_result = v.ex_res;
        memwb_rd = v.wb_rd; memwb_reg_write = v.wb_rw; memwb_result = v.wb_res;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.a = v.exp_a; e.b = v.exp_b; e.op = v.alu_op;
        e.rd = v.rd; e.rw = v.reg_write; e.mr = v.mem_read;
        sb_q.push_back(e);
    endtask

    task automatic expect_issue(input string tag);
        exp_t e;
        check({tag, " out_valid"}, 16'(out_valid), 16'd1);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, " A"}, 16'(A), e.a);
            check({tag, " B"}, 16'(B), e.b);
            check({tag, " ALUop"}, 16'(ALUop), 16'(e.op));
            check({tag, " out_rd"}, 16'(out_rd), 16'(e.rd));
            check({tag, " out_reg_write"}, 16'(out_reg_write), 16'(e.rw));
            check({tag, " out_mem_read"}, 16'(out_mem_read), 16'(e.mr));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " A"}, 16'(A), 16'd0);
        check({tag, " B"}, 16'(B), 16'd0);
        check({tag, " ALUop"}, 16'(ALUop), 16'd0);
        check({tag, " out_valid"}, 16'(out_valid), 16'd0);
        check({tag, " out_rd"}, 16'(out_rd), 16'd0);
        check({tag, " out_reg_write"}, 16'(out_reg_write), 16'd0);
        check({tag, " out_mem_read"}, 16'(out_mem_read), 16'd0);
        check({tag, " stall_count"}, 16'(stall_count), 16'd0);
        check({tag, " in_ready"}, 16'(in_ready), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        vec_t v;
        vec_t w;
        vec_t idle;

        idle = mk(3'd0, 3'd0, 16'd0, 16'd0, 1'b0, 16'd0, 2'b00, 3'd0, 1'b0, 1'b0,
                  3'd0, 1'b0, 1'b0, 16'd0, 3'd0, 1'b0, 16'd0, 16'd0, 16'd0);
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        apply(idle);

        //            rs1   rs2   rs1_data    rs2_data    imm? imm         op     rd    rw    mr    ex_rd ex_rw ex_mr ex_res      wb_rd wb_rw wb_res      exp_a       exp_b
        vecs[0] = mk(3'd1, 3'd2, 16'd30,     16'd30,     1'b0, 16'd0,      2'b01, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0,      3'd0, 1'b0, 16'd0,      16'd30,     16'd30);
        vecs[1] = mk(3'd3, 3'd4, 16'd11,     16'd22,     1'b0, 16'd0,      2'b00, 3'd1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 16'd100,    3'd3, 1'b1, 16'd7,      16'd100,    16'd22);
        vecs[2] = mk(3'd3, 3'd4, 16'd11,     16'd22,     1'b0, 16'd0,      2'b00, 3'd1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 16'd100,    3'd3, 1'b1, 16'd7,      16'd7,      16'd22);
        vecs[3] = mk(3'd0, 3'd2, 16'd55,     16'd9,      1'b0, 16'd0,      2'b01, 3'd2, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 16'd100,    3'd0, 1'b1, 16'd7,      16'd55,     16'd9);
        vecs[4] = mk(3'd1, 3'd3, 16'd1,      16'd2,      1'b1, 16'hFFFB,   2'b10, 3'd5, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 16'd100,    3'd0, 1'b0, 16'd0,      16'd1,      16'hFFFB);
        vecs[5] = mk(3'd5, 3'd6, 16'd3,      16'd4,      1'b0, 16'd0,      2'b01, 3'd7, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 16'd100,    3'd6, 1'b1, 16'h1234,   16'd100,    16'h1234);
        vecs[6] = mk(3'd2, 3'd4, 16'h8000,   16'h0003,   1'b1, 16'h0010,   2'b00, 3'd6, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 16'hDEAD,   3'd0, 1'b0, 16'd0,      16'h8000,   16'h0010);
        vecs[7] = mk(3'd7, 3'd7, 16'h00AA,   16'h0055,   1'b0, 16'd0,      2'b11, 3'd0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 16'h0F0F,   3'd7, 1'b1, 16'hF0F0,   16'h0F0F,   16'h0F0F);

        #1;
        check_all_zero("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("in_ready after reset", 16'(in_ready), 16'd1);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
            #1;
            check($sformatf("v%0d idle out_valid", i), 16'(out_valid), 16'd0);
            check($sformatf("v%0d in_ready", i), 16'(in_ready), 16'd1);
            push_exp(vecs[i]);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            expect_issue($sformatf("v%0d", i));
        end
        check("table stall_count", 16'(stall_count), 16'(exp_stall));

        // Load-use hazard on rs2: one HAZARD cycle, then issue with the MEM/WB value.
        v = mk(3'd1, 3'd5, 16'd10, 16'd20, 1'b0, 16'd0, 2'b01, 3'd2, 1'b1, 1'b0,
               3'd0, 1'b0, 1'b0, 16'd0, 3'd0, 1'b0, 16'd0, 16'd10, 16'h0BAD);
        @(negedge clk);
        apply(v); in_valid = 1'b1;
        #1;
        check("hz accept in_ready", 16'(in_ready), 16'd1);
        push_exp(v);
        @(negedge clk);
        in_valid = 1'b0;
        exmem_rd = 3'd5; exmem_reg_write = 1'b1; exmem_mem_read = 1'b1; exmem_result = 16'hDEAD;
        #1;
        check("hz detect out_valid", 16'(out_valid), 16'd0);
        check("hz detect in_ready", 16'(in_ready), 16'd0);
        @(negedge clk);
        exmem_reg_write = 1'b0; exmem_mem_read = 1'b0;
        memwb_rd = 3'd5; memwb_reg_write = 1'b1; memwb_result = 16'h0BAD;
        #1;
        check("hz cycle out_valid", 16'(out_valid), 16'd0);
        check("hz cycle in_ready", 16'(in_ready), 16'd0);
        check("hz cycle stall_count", 16'(stall_count), 16'(exp_stall));
        exp_stall++;
        @(negedge clk);
        #1;
        check("hz stall_count step", 16'(stall_count), 16'(exp_stall));
        expect_issue("hz issue");
        @(negedge clk);
        apply(idle);
        #1;
        check("hz drained out_valid", 16'(out_valid), 16'd0);

        // Back-pressure: out_ready low for three cycles while another instruction is offered.
        v = mk(3'd2, 3'd3, 16'h1111, 16'h2222, 1'b0, 16'd0, 2'b10, 3'd4, 1'b1, 1'b0,
               3'd0, 1'b0, 1'b0, 16'd0, 3'd0, 1'b0, 16'd0, 16'h1111, 16'h2222);
        w = mk(3'd1, 3'd1, 16'hAAAA, 16'hBBBB, 1'b0, 16'd0, 2'b00, 3'd6, 1'b1, 1'b0,
               3'd0, 1'b0, 1'b0, 16'd0, 3'd0, 1'b0, 16'd0, 16'hAAAA, 16'hBBBB);
        @(negedge clk);
        apply(v); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp accept in_ready", 16'(in_ready), 16'd1);
        push_exp(v);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            apply(w); in_valid = 1'b1; out_ready = 1'b0;
            #1;
            check($sformatf("bp%0d out_valid", k), 16'(out_valid), 16'd1);
            check($sformatf("bp%0d in_ready", k), 16'(in_ready), 16'd0);
            check($sformatf("bp%0d A", k), 16'(A), 16'h1111);
            check($sformatf("bp%0d B", k), 16'(B), 16'h2222);
            check($sformatf("bp%0d out_rd", k), 16'(out_rd), 16'd4);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        expect_issue("bp release");
        @(negedge clk);
        #1;
        check("bp single issue", 16'(out_valid), 16'd0);

        // Flush with an offer while EMPTY, then flush of a held entry.
        @(negedge clk);
        apply(vecs[0]); in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        #1;
        check("flush empty out_valid", 16'(out_valid), 16'd0);
        check("flush empty in_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        apply(vecs[1]); in_valid = 1'b1;
        @(negedge clk);
        apply(vecs[5]); in_valid = 1'b1; flush = 1'b1; out_ready = 1'b0;
        #1;
        check("flush held out_valid before", 16'(out_valid), 16'd1);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #1;
        check("flush held out_valid after", 16'(out_valid), 16'd0);

        // Long hazard to saturate stall_count, then asynchronous reset mid-HAZARD.
        v = mk(3'd6, 3'd1, 16'h7777, 16'h0001, 1'b1, 16'h0042, 2'b10, 3'd7, 1'b1, 1'b1,
               3'd0, 1'b0, 1'b0, 16'd0, 3'd0, 1'b0, 16'd0, 16'h7777, 16'h0042);
        @(negedge clk);
        apply(v); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("sat accept in_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        in_valid = 1'b0;
        exmem_rd = 3'd6; exmem_reg_write = 1'b1; exmem_mem_read = 1'b1; exmem_result = 16'hFFFF;
        memwb_rd = 3'd6; memwb_reg_write = 1'b1; memwb_result = 16'h5555;
        repeat (305) @(negedge clk);
        exp_stall = (exp_stall + 304 > 255) ? 255 : exp_stall + 304;
        #1;
        check("sat stall_count", 16'(stall_count), 16'(exp_stall));
        check("sat out_valid", 16'(out_valid), 16'd0);
        check("sat in_ready", 16'(in_ready), 16'd0);
        check("sat out_rd held", 16'(out_rd), 16'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid-hazard reset");
        @(negedge clk);
        rst_n = 1'b1;
        apply(idle);
        @(negedge clk);
        #1;
        check("post reset in_ready", 16'(in_ready), 16'd1);
        check("post reset out_valid", 16'(out_valid), 16'd0);
        check("post reset stall_count", 16'(stall_count), 16'd0);

        check("scoreboard drained", 16'(sb_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
